// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multi-cycle CPU. It steps each instruction through fetch,
// decode, execute, memory and writeback, and bounds every memory wait with a timeout counter.
module multicycle_main_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_o,
  output logic       mem_err_o,
  output logic [3:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             wait_state, timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_source_o  = 2'b00;
    illegal_o    = 1'b0;
    mem_err_o    = 1'b0;

    wait_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    timeout    = wait_state && !mem_ready_i && (wait_cnt == WAIT_LAST);

    case (state)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_next = DECODE;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_LW, OP_SW:     state_next = MEM_ADDR;
          OP_RTYPE:         state_next = EXEC_R;
          OP_ADDI, OP_SLTI: state_next = EXEC_I;
          OP_BEQ:           state_next = BRANCH;
          OP_J:             state_next = JUMP;
          default: begin
            illegal_o  = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_next  = (opcode_i == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_next   = FETCH;
      end
      MEM_WRITE: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) state_next = FETCH;
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        state_next  = R_WB;
      end
      R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_next  = FETCH;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (opcode_i == OP_SLTI) ? 3'b100 : 3'b000;
        state_next  = I_WB;
      end
      I_WB: begin
        reg_write_o = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b001;
        pc_source_o = 2'b01;
        pc_write_o  = zero_i;
        state_next  = FETCH;
      end
      JUMP: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
        state_next  = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // A timed-out wait abandons the access and restarts from a fresh fetch.
    if (timeout) begin
      mem_err_o  = 1'b1;
      state_next = FETCH;
    end

    if (timeout || (state_next != state))
      wait_cnt_next = '0;
    else if (wait_state && !mem_ready_i)
      wait_cnt_next = wait_cnt + CNT_W'(1);
    else
      wait_cnt_next = wait_cnt;

    // Reset blanks every output, including those that follow mem_ready_i or zero_i.
    if (rst_i) begin
      pc_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_dst_o    = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      pc_source_o  = 2'b00;
      illegal_o    = 1'b0;
      mem_err_o    = 1'b0;
    end
  end

  assign state_o = state;

endmodule
